// File: rtl/gpio_seq_pkg.sv
// Shared definitions for the gpio pattern sequencer: opcode and FSM encodings,
// gpio output-register indices and the emesh datamode used for every write.
package gpio_seq_pkg;

    // Step opcodes as stored in the table
    typedef enum logic [1:0] {
        OP_OUT    = 2'd0,
        OP_OUTSET = 2'd1,
        OP_OUTCLR = 2'd2,
        OP_OUTXOR = 2'd3
    } opcode_t;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DELAY = 2'd2
    } state_t;

    // Output-register indices, mirroring the gpio register map
    localparam logic [3:0] GPIO_OUT    = 4'd2;
    localparam logic [3:0] GPIO_OUTCLR = 4'd3;
    localparam logic [3:0] GPIO_OUTSET = 4'd4;
    localparam logic [3:0] GPIO_OUTXOR = 4'd5;

    // 32-bit word transfer
    localparam logic [1:0] DATAMODE_WORD = 2'b10;

    // Translate a step opcode into the gpio register it writes
    function automatic logic [3:0] opToRegIndex(input opcode_t op);
        logic [3:0] idx;
        case (op)
            OP_OUT:    idx = GPIO_OUT;
            OP_OUTSET: idx = GPIO_OUTSET;
            OP_OUTCLR: idx = GPIO_OUTCLR;
            OP_OUTXOR: idx = GPIO_OUTXOR;
            default:   idx = GPIO_OUT;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/gpio_seq_emesh2packet.sv
// Packs emesh transaction fields into the flat packet layout:
// {srcaddr, data, dstaddr, ctrlmode[4:0], datamode[1:0], write}.
module gpio_seq_emesh2packet #(
    parameter int AW = 32,
    parameter int PW = 104
) (
    input  logic          write_out,
    input  logic [1:0]    datamode_out,
    input  logic [4:0]    ctrlmode_out,
    input  logic [AW-1:0] dstaddr_out,
    input  logic [AW-1:0] data_out,
    input  logic [AW-1:0] srcaddr_out,
    output logic [PW-1:0] packet_out
);

    assign packet_out = {srcaddr_out, data_out, dstaddr_out,
                         ctrlmode_out, datamode_out, write_out};

endmodule

// File: rtl/gpio_seq.sv
// Autonomous gpio pattern sequencer. Plays a table of output-register writes
// to a gpio block over emesh, one packet per step, with a programmable idle
// gap after each accepted packet.
// Optional build macro GPIO_SEQ_LOOPCNT_EN: adds loop_cnt so a looping run
// stops by itself after loop_cnt+1 passes instead of repeating until stop.
module gpio_seq
    import gpio_seq_pkg::*;
#(
    parameter int N     = 24,
    parameter int AW    = 32,
    parameter int PW    = 104,
    parameter int DEPTH = 16,
    parameter int DW    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_write,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic [1:0]               cfg_op,
    input  logic [N-1:0]             cfg_data,
    input  logic [DW-1:0]            cfg_delay,
    input  logic [AW-1:0]            base_addr,
    input  logic [$clog2(DEPTH)-1:0] last_step,
    input  logic                     loop_en,
`ifdef GPIO_SEQ_LOOPCNT_EN
    input  logic [7:0]               loop_cnt,
`endif
    input  logic                     start,
    input  logic                     stop,
    output logic                     access_out,
    output logic [PW-1:0]            packet_out,
    input  logic                     wait_in,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH)-1:0] step_idx
);

    localparam int IW = $clog2(DEPTH);

    // Step table (deliberately not reset)
    logic [1:0]    r_tblOp    [DEPTH];
    logic [N-1:0]  r_tblData  [DEPTH];
    logic [DW-1:0] r_tblDelay [DEPTH];

    state_t        r_state;
    state_t        w_nextState;
    logic [IW-1:0] r_idx;
    logic [DW-1:0] r_delay;
    logic [DW-1:0] r_count;
    logic          r_stopLatch;
    logic          r_done;
    logic          r_write;
    logic [1:0]    r_datamode;
    logic [AW-1:0] r_dstaddr;
    logic [AW-1:0] r_dataWord;

    logic          w_accept;
    logic          w_stopEff;
    logic          w_start;
    logic          w_delayExpire;
    logic          w_issueAdvance;
    logic          w_advance;
    logic          w_atLast;
    logic          w_wrap;
    logic          w_finish;
    logic          w_load;
    logic [IW-1:0] w_loadIdx;
    logic          w_unusedBase;

    // Low address bits are replaced by the register index
    assign w_unusedBase = ^base_addr[6:0];

    assign w_accept       = (r_state == S_ISSUE) & ~wait_in;
    assign w_stopEff      = r_stopLatch | stop;
    assign w_start        = (r_state == S_IDLE) & start & ~stop;
    assign w_delayExpire  = (r_state == S_DELAY) & ~stop & (r_count == DW'(1));
    assign w_issueAdvance = w_accept & ~w_stopEff & (r_delay == '0);
    assign w_advance      = w_issueAdvance | w_delayExpire;
    assign w_atLast       = (r_idx == last_step);

`ifdef GPIO_SEQ_LOOPCNT_EN
    logic [7:0] r_pass;
    assign w_wrap = loop_en & (r_pass != loop_cnt);

    // Count completed passes of a looping run; restart from zero on start
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_pass <= '0;
        else if (w_start)
            r_pass <= '0;
        else if (w_advance && w_atLast && w_wrap)
            r_pass <= r_pass + 8'd1;
    end
`else
    assign w_wrap = loop_en;
`endif

    assign w_finish  = w_advance & w_atLast & ~w_wrap;
    assign w_load    = w_start | (w_advance & ~w_finish);
    assign w_loadIdx = (w_start || w_atLast) ? '0 : r_idx + IW'(1);

    // Table write port, usable even while a run is in progress
    always_ff @(posedge clk) begin
        if (cfg_write) begin
            r_tblOp[cfg_addr]    <= cfg_op;
            r_tblData[cfg_addr]  <= cfg_data;
            r_tblDelay[cfg_addr] <= cfg_delay;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_nextState;
    end

    // FSM next-state logic
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start)
                    w_nextState = S_ISSUE;
            end
            S_ISSUE: begin
                if (w_accept) begin
                    if (w_stopEff)
                        w_nextState = S_IDLE;
                    else if (r_delay != '0)
                        w_nextState = S_DELAY;
                    else if (w_finish)
                        w_nextState = S_IDLE;
                    else
                        w_nextState = S_ISSUE;
                end
            end
            S_DELAY: begin
                if (stop)
                    w_nextState = S_IDLE;
                else if (r_count == DW'(1))
                    w_nextState = w_finish ? S_IDLE : S_ISSUE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // FSM outputs; access_out follows the state so reset drops it at once
    always_comb begin
        access_out = (r_state == S_ISSUE);
        busy       = (r_state != S_IDLE);
    end

    // Capture the step entry into the packet fields on every entry to ISSUE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx      <= '0;
            r_delay    <= '0;
            r_write    <= 1'b0;
            r_datamode <= 2'b00;
            r_dstaddr  <= '0;
            r_dataWord <= '0;
        end else if (w_load) begin
            r_idx      <= w_loadIdx;
            r_delay    <= r_tblDelay[w_loadIdx];
            r_write    <= 1'b1;
            r_datamode <= DATAMODE_WORD;
            r_dstaddr  <= {base_addr[AW-1:7],
                           opToRegIndex(opcode_t'(r_tblOp[w_loadIdx])), 3'b000};
            r_dataWord <= {{(AW-N){1'b0}}, r_tblData[w_loadIdx]};
        end
    end

    // Inter-step delay counter, loaded at accept and counted down in DELAY
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_count <= '0;
        else if (w_accept && !w_stopEff && r_delay != '0)
            r_count <= r_delay;
        else if (r_state == S_DELAY)
            r_count <= stop ? '0 : r_count - DW'(1);
    end

    // Remember a stop seen while a packet is stalled, and pulse done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stopLatch <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_stopLatch <= (r_state == S_ISSUE) & ~w_accept & w_stopEff;
            r_done      <= w_finish;
        end
    end

    assign done     = r_done;
    assign step_idx = r_idx;

    gpio_seq_emesh2packet #(
        .AW (AW),
        .PW (PW)
    ) u_packer (
        .write_out    (r_write),
        .datamode_out (r_datamode),
        .ctrlmode_out (5'b00000),
        .dstaddr_out  (r_dstaddr),
        .data_out     (r_dataWord),
        .srcaddr_out  ({AW{1'b0}}),
        .packet_out   (packet_out)
    );

endmodule

// File: tb/tb_gpio_seq.sv
// Directed testbench for gpio_seq: timing of packets, stalls, stop handling,
// looping and asynchronous reset, checked against hand-computed values.
module tb_gpio_seq;

    localparam logic [31:0] BASE = 32'h8200_0055;

    localparam logic [1:0] C_OUT    = 2'd0;
    localparam logic [1:0] C_OUTSET = 2'd1;
    localparam logic [1:0] C_OUTCLR = 2'd2;
    localparam logic [1:0] C_OUTXOR = 2'd3;

    localparam logic [3:0] R_OUT    = 4'd2;
    localparam logic [3:0] R_OUTCLR = 4'd3;
    localparam logic [3:0] R_OUTSET = 4'd4;
    localparam logic [3:0] R_OUTXOR = 4'd5;

    logic         clk;
    logic         reset;
    logic         cfg_write;
    logic [3:0]   cfg_addr;
    logic [1:0]   cfg_op;
    logic [23:0]  cfg_data;
    logic [15:0]  cfg_delay;
    logic [31:0]  base_addr;
    logic [3:0]   last_step;
    logic         loop_en;
    logic [7:0]   loop_cnt;
    logic         start;
    logic         stop;
    logic         access_out;
    logic [103:0] packet_out;
    logic         wait_in;
    logic         busy;
    logic         done;
    logic [3:0]   step_idx;

    int testsRun;
    int testsFailed;

    gpio_seq dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_write  (cfg_write),
        .cfg_addr   (cfg_addr),
        .cfg_op     (cfg_op),
        .cfg_data   (cfg_data),
        .cfg_delay  (cfg_delay),
        .base_addr  (base_addr),
        .last_step  (last_step),
        .loop_en    (loop_en),
`ifdef GPIO_SEQ_LOOPCNT_EN
        .loop_cnt   (loop_cnt),
`endif
        .start      (start),
        .stop       (stop),
        .access_out (access_out),
        .packet_out (packet_out),
        .wait_in    (wait_in),
        .busy       (busy),
        .done       (done),
        .step_idx   (step_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Expected emesh write packet for a register index and data word
    function automatic logic [103:0] expPkt(input logic [3:0] regIdx, input logic [23:0] d);
        return {32'h0, 8'h0, d, BASE[31:7], regIdx, 3'b000, 5'b00000, 2'b10, 1'b1};
    endfunction

    // Recorder: logs accepted packets, done pulses and stall behaviour per cycle
    logic         recOn;
    int           cyc;
    int           accCyc[$];
    int           accIdx[$];
    logic [103:0] accPkt[$];
    int           doneCyc[$];
    int           stallCount;
    logic         prevAccess;
    logic         prevWait;
    logic [103:0] prevPkt;
    logic [23:0]  gpioModel;

    function automatic int accCycAt(input int i);
        return (i < accCyc.size()) ? accCyc[i] : -1;
    endfunction

    function automatic int accIdxAt(input int i);
        return (i < accIdx.size()) ? accIdx[i] : -1;
    endfunction

    function automatic logic [103:0] accPktAt(input int i);
        return (i < accPkt.size()) ? accPkt[i] : '1;
    endfunction

    function automatic int doneAt(input int i);
        return (i < doneCyc.size()) ? doneCyc[i] : -1;
    endfunction

    task automatic clearRec();
        accCyc.delete();
        accIdx.delete();
        accPkt.delete();
        doneCyc.delete();
        stallCount = 0;
        prevAccess = 1'b0;
        prevWait   = 1'b0;
        prevPkt    = '0;
        gpioModel  = '0;
        cyc        = 0;
    endtask

    always @(negedge clk) begin
        if (recOn) begin
            if (prevAccess && prevWait) begin
                checkOutput("stallHoldAccess", 128'(access_out), 128'(1'b1));
                checkOutput("stallHoldPacket", 128'(packet_out), 128'(prevPkt));
            end
            if (access_out && wait_in)
                stallCount++;
            if (access_out && !wait_in) begin
                accCyc.push_back(cyc);
                accIdx.push_back(int'(step_idx));
                accPkt.push_back(packet_out);
                case (packet_out[14:11])
                    R_OUT:    gpioModel = packet_out[63:40];
                    R_OUTSET: gpioModel = gpioModel | packet_out[63:40];
                    R_OUTCLR: gpioModel = gpioModel & ~packet_out[63:40];
                    R_OUTXOR: gpioModel = gpioModel ^ packet_out[63:40];
                    default:  gpioModel = 24'hDEAD00;
                endcase
            end
            if (done)
                doneCyc.push_back(cyc);
            prevAccess = access_out;
            prevWait   = wait_in;
            prevPkt    = packet_out;
            cyc++;
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Write one table entry
    task automatic applyStimulus(input logic [3:0] idx, input logic [1:0] op,
                                 input logic [23:0] d, input logic [15:0] dly);
        nextCycle();
        cfg_write = 1'b1;
        cfg_addr  = idx;
        cfg_op    = op;
        cfg_data  = d;
        cfg_delay = dly;
        nextCycle();
        cfg_write = 1'b0;
    endtask

    // Begin a run: the cycle in which start is high is cycle 0
    task automatic startRun();
        nextCycle();
        clearRec();
        start = 1'b1;
        recOn = 1'b1;
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        recOn       = 1'b0;
        clearRec();
        reset       = 1'b1;
        cfg_write   = 1'b0;
        cfg_addr    = '0;
        cfg_op      = '0;
        cfg_data    = '0;
        cfg_delay   = '0;
        base_addr   = BASE;
        last_step   = 4'd2;
        loop_en     = 1'b0;
        loop_cnt    = 8'd0;
        start       = 1'b0;
        stop        = 1'b0;
        wait_in     = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        checkOutput("rstAccess", 128'(access_out), 128'(1'b0));
        checkOutput("rstBusy", 128'(busy), 128'(1'b0));
        checkOutput("rstDone", 128'(done), 128'(1'b0));
        checkOutput("rstStepIdx", 128'(step_idx), 128'(4'd0));
        checkOutput("rstPacket", 128'(packet_out), 128'(104'd0));

        applyStimulus(4'd0, C_OUT,    24'h00000F, 16'd2);
        applyStimulus(4'd1, C_OUTSET, 24'h000100, 16'd0);
        applyStimulus(4'd2, C_OUTXOR, 24'h00000F, 16'd1);

        // Basic three-step run
        startRun();
        for (int c = 1; c <= 15; c++) begin
            nextCycle();
            start = 1'b0;
        end
        recOn = 1'b0;
        checkOutput("t1AccCount", 128'(accCyc.size()), 128'(3));
        checkOutput("t1Acc0", 128'(accCycAt(0)), 128'(1));
        checkOutput("t1Acc1", 128'(accCycAt(1)), 128'(4));
        checkOutput("t1Acc2", 128'(accCycAt(2)), 128'(5));
        checkOutput("t1Pkt0", 128'(accPktAt(0)), 128'(expPkt(R_OUT, 24'h00000F)));
        checkOutput("t1Pkt1", 128'(accPktAt(1)), 128'(expPkt(R_OUTSET, 24'h000100)));
        checkOutput("t1Pkt2", 128'(accPktAt(2)), 128'(expPkt(R_OUTXOR, 24'h00000F)));
        checkOutput("t1DoneCount", 128'(doneCyc.size()), 128'(1));
        checkOutput("t1DoneCyc", 128'(doneAt(0)), 128'(7));
        checkOutput("t1GpioOut", 128'(gpioModel), 128'(24'h000100));
        checkOutput("t1BusyEnd", 128'(busy), 128'(1'b0));

        // Same table, step 0 stalled for five cycles
        startRun();
        wait_in = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            nextCycle();
            start   = 1'b0;
            wait_in = (c <= 5);
        end
        recOn = 1'b0;
        checkOutput("t2StallCycles", 128'(stallCount), 128'(5));
        checkOutput("t2AccCount", 128'(accCyc.size()), 128'(3));
        checkOutput("t2Acc0", 128'(accCycAt(0)), 128'(6));
        checkOutput("t2Acc1", 128'(accCycAt(1)), 128'(9));
        checkOutput("t2Acc2", 128'(accCycAt(2)), 128'(10));
        checkOutput("t2Idx0", 128'(accIdxAt(0)), 128'(0));
        checkOutput("t2Idx1", 128'(accIdxAt(1)), 128'(1));
        checkOutput("t2DoneCyc", 128'(doneAt(0)), 128'(12));
        checkOutput("t2GpioOut", 128'(gpioModel), 128'(24'h000100));

        // Stop during a long delay after step 0
        applyStimulus(4'd0, C_OUT, 24'h00000F, 16'd10);
        startRun();
        for (int c = 1; c <= 30; c++) begin
            nextCycle();
            start = 1'b0;
            stop  = (c == 4);
            if (c == 4) begin
                @(negedge clk);
                checkOutput("t3BusyInDelay", 128'(busy), 128'(1'b1));
            end
            if (c == 5) begin
                @(negedge clk);
                checkOutput("t3BusyAfterStop", 128'(busy), 128'(1'b0));
            end
        end
        recOn = 1'b0;
        checkOutput("t3AccCount", 128'(accCyc.size()), 128'(1));
        checkOutput("t3DoneCount", 128'(doneCyc.size()), 128'(0));
        checkOutput("t3AccessEnd", 128'(access_out), 128'(1'b0));

        // Stop while step 0 is stalled by wait_in
        applyStimulus(4'd0, C_OUT, 24'h00000F, 16'd2);
        startRun();
        wait_in = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            nextCycle();
            start   = 1'b0;
            wait_in = (c <= 4);
            stop    = (c == 2);
            if (c == 6) begin
                @(negedge clk);
                checkOutput("t4BusyAfterAcc", 128'(busy), 128'(1'b0));
            end
        end
        recOn = 1'b0;
        checkOutput("t4AccCount", 128'(accCyc.size()), 128'(1));
        checkOutput("t4Acc0", 128'(accCycAt(0)), 128'(5));
        checkOutput("t4Pkt0", 128'(accPktAt(0)), 128'(expPkt(R_OUT, 24'h00000F)));
        checkOutput("t4DoneCount", 128'(doneCyc.size()), 128'(0));

        // Two-step loop
        applyStimulus(4'd1, C_OUTSET, 24'h000100, 16'd3);
        last_step = 4'd1;
        loop_en   = 1'b1;
        loop_cnt  = 8'd2;
        startRun();
        for (int c = 1; c <= 30; c++) begin
            nextCycle();
            start = 1'b0;
`ifdef GPIO_SEQ_LOOPCNT_EN
            stop  = 1'b0;
`else
            stop  = (c == 20);
`endif
        end
        recOn = 1'b0;
        stop  = 1'b0;
        checkOutput("t5AccCount", 128'(accCyc.size()), 128'(6));
        checkOutput("t5Acc0", 128'(accCycAt(0)), 128'(1));
        checkOutput("t5Acc1", 128'(accCycAt(1)), 128'(4));
        checkOutput("t5Acc2", 128'(accCycAt(2)), 128'(8));
        checkOutput("t5Acc3", 128'(accCycAt(3)), 128'(11));
        checkOutput("t5Acc4", 128'(accCycAt(4)), 128'(15));
        checkOutput("t5Acc5", 128'(accCycAt(5)), 128'(18));
        for (int i = 0; i < 6; i++)
            checkOutput($sformatf("t5Idx%0d", i), 128'(accIdxAt(i)), 128'(i % 2));
`ifdef GPIO_SEQ_LOOPCNT_EN
        checkOutput("t5DoneCount", 128'(doneCyc.size()), 128'(1));
        checkOutput("t5DoneCyc", 128'(doneAt(0)), 128'(22));
`else
        checkOutput("t5DoneCount", 128'(doneCyc.size()), 128'(0));
`endif
        checkOutput("t5BusyEnd", 128'(busy), 128'(1'b0));

        // Reset while a packet is pending, then replay from step 0
        applyStimulus(4'd1, C_OUTSET, 24'h000100, 16'd0);
        last_step = 4'd2;
        loop_en   = 1'b0;
        startRun();
        wait_in = 1'b1;
        nextCycle();
        start = 1'b0;
        nextCycle();
        recOn = 1'b0;
        @(negedge clk);
        checkOutput("t6AccessBefore", 128'(access_out), 128'(1'b1));
        #1 reset = 1'b1;
        #1;
        checkOutput("t6AccessRst", 128'(access_out), 128'(1'b0));
        checkOutput("t6BusyRst", 128'(busy), 128'(1'b0));
        checkOutput("t6IdxRst", 128'(step_idx), 128'(4'd0));
        checkOutput("t6PacketRst", 128'(packet_out), 128'(104'd0));
        nextCycle();
        reset   = 1'b0;
        wait_in = 1'b0;
        startRun();
        for (int c = 1; c <= 15; c++) begin
            nextCycle();
            start = 1'b0;
        end
        recOn = 1'b0;
        checkOutput("t6AccCount", 128'(accCyc.size()), 128'(3));
        checkOutput("t6Acc0", 128'(accCycAt(0)), 128'(1));
        checkOutput("t6Idx0", 128'(accIdxAt(0)), 128'(0));
        checkOutput("t6Pkt0", 128'(accPktAt(0)), 128'(expPkt(R_OUT, 24'h00000F)));
        checkOutput("t6DoneCyc", 128'(doneAt(0)), 128'(7));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
